alu_mc: RTL and testbench

Multi-cycle, parametrised ALU for the R4 core's execute stage. It replaces the purely combinational ALU and adds:
- fully defined `slt`/`sltu`;
- shift amounts masked to `log2(XLEN)` bits;
- a registered valid/ready handshake;
- an iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

Base ops complete in one cycle; M-extension ops stall the pipeline via `in_ready`.

---
 rtl/alu_mc_pkg.sv | 59 +++++
 rtl/alu_mc_base.sv | 41 ++++
 rtl/alu_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: base/M-extension opcode enums,
// FSM states and opcode classification helpers.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_SLTU = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Ops whose first operand is interpreted as signed (mulhsu: in1 only).
    function automatic logic is_signed_md(input md_op_e f);
        case (f)
            MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_md(input md_op_e f);
        case (f)
            MD_DIV, MD_DIVU, MD_REM, MD_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_md(input md_op_e f);
        case (f)
            MD_REM, MD_REMU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mc_base.sv
// Combinational single-cycle datapath for the base integer ops.
// Undefined opcodes raise illegal and drive a zero result.
module alu_mc_base
    import alu_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] y,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-2:0] PAD = {(XLEN-1){1'b0}};

    logic [SW-1:0] shamt_s;

    assign shamt_s = b[SW-1:0];

    // Opcode decode and result selection.
    always_comb begin
        y       = {XLEN{1'b0}};
        illegal = 1'b0;
        case (alu_op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLL:  y = a << shamt_s;
            OP_SLT:  y = {PAD, ($signed(a) < $signed(b))};
            OP_SLTU: y = {PAD, (a < b)};
            OP_XOR:  y = a ^ b;
            OP_SRL:  y = a >> shamt_s;
            OP_SRA:  y = $signed(a) >>> shamt_s;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops plus an iterative shift-add multiplier
// and restoring divider sharing one 2*XLEN accumulator, behind a valid/ready pair.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      op,
    input  logic            m_op,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            negative,
    output logic            zero,
    output logic            illegal
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};

    state_e              state_r, state_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [2*XLEN-1:0]   acc_r, acc_s;
    logic [XLEN-1:0]     opa_r, opa_s;
    logic                neg_r, neg_s;
    logic                sa_r, sa_s;
    md_op_e              md_r, md_s;
    logic [XLEN-1:0]     result_r, result_s;
    logic                out_valid_r, out_valid_s;
    logic                illegal_r, illegal_s;

    logic [XLEN-1:0]     base_y_s;
    logic                base_ill_s;
    md_op_e              md_in_s;
    logic                a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                div_zero_s, div_ovf_s;
    logic                accept_s;
    logic [XLEN:0]       madd_s, dsh_s, dsub_s;
    logic [2*XLEN-1:0]   mul_next_s, div_next_s, prod_s;
    logic [XLEN-1:0]     quot_s, rem_s, fix_s;

    alu_mc_base #(.XLEN(XLEN)) u_base (
        .a       (in1),
        .b       (in2),
        .op      (op),
        .y       (base_y_s),
        .illegal (base_ill_s)
    );

    assign in_ready  = (state_r == ST_IDLE) && !(out_valid_r && !out_ready);
    assign accept_s  = in_valid && in_ready && !flush;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign illegal   = illegal_r;
    assign negative  = result_r[XLEN-1];
    assign zero      = ~|result_r;

    // Operand sign handling: mulhsu treats only in1 as signed.
    assign md_in_s    = md_op_e'(funct3);
    assign a_neg_s    = is_signed_md(md_in_s) && in1[XLEN-1];
    assign b_neg_s    = is_signed_md(md_in_s) && (md_in_s != MD_MULHSU) && in2[XLEN-1];
    assign a_mag_s    = a_neg_s ? (ZERO - in1) : in1;
    assign b_mag_s    = b_neg_s ? (ZERO - in2) : in2;
    assign div_zero_s = is_div_md(md_in_s) && (in2 == ZERO);
    assign div_ovf_s  = ((md_in_s == MD_DIV) || (md_in_s == MD_REM)) && (in1 == SMIN) && (in2 == ONES);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign madd_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opa_r} : {(XLEN+1){1'b0}});
    assign mul_next_s = {madd_s, acc_r[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    assign dsh_s      = acc_r[2*XLEN-1:XLEN-1];
    assign dsub_s     = dsh_s - {1'b0, opa_r};
    assign div_next_s = dsub_s[XLEN] ? {dsh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                                     : {dsub_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};

    // Sign fix-up and half/quotient/remainder selection.
    always_comb begin
        fix_s  = ZERO;
        prod_s = neg_r ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
        quot_s = neg_r ? (ZERO - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        rem_s  = sa_r ? (ZERO - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
        case (md_r)
            MD_MUL:                       fix_s = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_s = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_s = quot_s;
            MD_REM, MD_REMU:              fix_s = rem_s;
            default:                      fix_s = ZERO;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        acc_s       = acc_r;
        opa_s       = opa_r;
        neg_s       = neg_r;
        sa_s        = sa_r;
        md_s        = md_r;
        result_s    = result_r;
        out_valid_s = out_valid_r;
        illegal_s   = illegal_r;
        if (flush) begin
            state_s     = ST_IDLE;
            cnt_s       = CNT_ZERO;
            out_valid_s = 1'b0;
            result_s    = ZERO;
            illegal_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        out_valid_s = 1'b1;
                        illegal_s   = 1'b0;
                        if (!m_op) begin
                            result_s  = base_ill_s ? ZERO : base_y_s;
                            illegal_s = base_ill_s;
                        end else if (EN_M == 1'b0) begin
                            result_s  = ZERO;
                            illegal_s = 1'b1;
                        end else if (div_zero_s) begin
                            result_s = is_rem_md(md_in_s) ? in1 : ONES;
                        end else if (div_ovf_s) begin
                            result_s = is_rem_md(md_in_s) ? ZERO : in1;
                        end else begin
                            out_valid_s = 1'b0;
                            md_s        = md_in_s;
                            neg_s       = a_neg_s ^ b_neg_s;
                            sa_s        = a_neg_s;
                            cnt_s       = CNT_LAST;
                            if (is_div_md(md_in_s)) begin
                                state_s = ST_DIV;
                                acc_s   = {ZERO, a_mag_s};
                                opa_s   = b_mag_s;
                            end else begin
                                state_s = ST_MUL;
                                acc_s   = {ZERO, b_mag_s};
                                opa_s   = a_mag_s;
                            end
                        end
                    end else if (out_valid_r && out_ready) begin
                        out_valid_s = 1'b0;
                    end else begin
                        out_valid_s = out_valid_r;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_s = (state_r == ST_MUL) ? mul_next_s : div_next_s;
                    if (cnt_r == CNT_ZERO) begin
                        state_s = ST_FIX;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_FIX: begin
                    result_s    = fix_s;
                    illegal_s   = 1'b0;
                    out_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_s = 1'b0;
                        state_s     = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            acc_r       <= {(2*XLEN){1'b0}};
            opa_r       <= ZERO;
            neg_r       <= 1'b0;
            sa_r        <= 1'b0;
            md_r        <= MD_MUL;
            result_r    <= ZERO;
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            opa_r       <= opa_s;
            neg_r       <= neg_s;
            sa_r        <= sa_s;
            md_r        <= md_s;
            result_r    <= result_s;
            out_valid_r <= out_valid_s;
            illegal_r   <= illegal_s;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32): directed table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_mc;

    logic        clk, reset, in_valid, m_op, flush, out_ready;
    logic [31:0] in1, in2;
    logic [3:0]  op;
    logic [2:0]  funct3;
    logic        in_ready, out_valid, negative, zero, illegal;
    logic [31:0] result;
    logic        in_ready0, out_valid0, negative0, zero0, illegal0;
    logic [31:0] result0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    alu_mc #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .m_op(m_op), .funct3(funct3), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .negative(negative), .zero(zero), .illegal(illegal)
    );

    alu_mc #(.XLEN(32), .EN_M(1'b0)) dut_nom (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in1(in1), .in2(in2), .op(op), .m_op(m_op), .funct3(funct3), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
        .negative(negative0), .zero(zero0), .illegal(illegal0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [3:0]  o;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    endtask

    // Reference model: {illegal, result} from plain arithmetic on the op rules.
    function automatic logic [32:0] model(input logic m, input logic [3:0] o, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic [4:0] sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        sh = b[4:0];
        if (!m) begin
            case (o)
                4'd0: return {1'b0, a + b};
                4'd1: return {1'b0, a - b};
                4'd2: return {1'b0, a << sh};
                4'd3: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
                4'd4: return {1'b0, 31'd0, (a < b)};
                4'd5: return {1'b0, a ^ b};
                4'd6: return {1'b0, a >> sh};
                4'd7: return {1'b0, 32'($signed(a) >>> sh)};
                4'd8: return {1'b0, a | b};
                4'd9: return {1'b0, a & b};
                default: return {1'b1, 32'd0};
            endcase
        end
        case (f)
            3'd0: begin p = ua * ub; return {1'b0, p[31:0]}; end
            3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
            3'd2: begin p = sa * longint'(ub); return {1'b0, p[63:32]}; end
            3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
            3'd4: begin
                if (b == 32'd0) return {1'b0, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, a};
                return {1'b0, 32'(ia / ib)};
            end
            3'd5: return (b == 32'd0) ? {1'b0, 32'hFFFFFFFF} : {1'b0, a / b};
            3'd6: begin
                if (b == 32'd0) return {1'b0, a};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0};
                return {1'b0, 32'(ia % ib)};
            end
            default: return (b == 32'd0) ? {1'b0, a} : {1'b0, a % b};
        endcase
    endfunction

    // Edges between the accept edge and out_valid becoming visible.
    function automatic int model_lat(input logic m, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
        if (!m) return 0;
        if (f[2] && b == 32'd0) return 0;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 16));
            default: return $urandom();
        endcase
    endfunction

    task automatic run_op(input logic m, input logic [3:0] o, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic ill, input int lat, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, ".rdy"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; m_op = m; op = o; funct3 = f; in1 = a; in2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, ".lat"}, 32'(n), 32'(lat));
        chk({name, ".res"}, result, exp);
        chk({name, ".ill"}, {31'd0, illegal}, {31'd0, ill});
        chk({name, ".zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        chk({name, ".neg"}, {31'd0, negative}, {31'd0, exp[31]});
    endtask

    initial begin
        int n, seen;
        logic [32:0] r;
        logic rm;
        logic [3:0] ro;
        logic [2:0] rf;
        logic [31:0] ra, rb;

        tbl[0]  = '{1'b0, 4'b0111, 3'd0, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 0};
        tbl[1]  = '{1'b0, 4'b0011, 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 0};
        tbl[2]  = '{1'b0, 4'b0100, 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 0};
        tbl[3]  = '{1'b0, 4'b0000, 3'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 0};
        tbl[4]  = '{1'b0, 4'b0001, 3'd0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 0};
        tbl[5]  = '{1'b0, 4'b0010, 3'd0, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 0};
        tbl[6]  = '{1'b0, 4'b0110, 3'd0, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 0};
        tbl[7]  = '{1'b0, 4'b0101, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 0};
        tbl[8]  = '{1'b0, 4'b1000, 3'd0, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 0};
        tbl[9]  = '{1'b0, 4'b1001, 3'd0, 32'h0000FF00, 32'h00000FF0, 32'h00000F00, 1'b0, 0};
        tbl[10] = '{1'b0, 4'b1010, 3'd0, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 0};
        tbl[11] = '{1'b1, 4'b0000, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};
        tbl[12] = '{1'b1, 4'b0000, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33};
        tbl[13] = '{1'b1, 4'b0000, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
        tbl[14] = '{1'b1, 4'b0000, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
        tbl[15] = '{1'b1, 4'b0000, 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33};
        tbl[16] = '{1'b1, 4'b0000, 3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33};
        tbl[17] = '{1'b1, 4'b0000, 3'd5, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
        tbl[18] = '{1'b1, 4'b0000, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0};
        tbl[19] = '{1'b1, 4'b0000, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0};
        tbl[20] = '{1'b1, 4'b0000, 3'd7, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 0};
        tbl[21] = '{1'b1, 4'b0000, 3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 33};
        tbl[22] = '{1'b1, 4'b0000, 3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 33};

        reset = 1'b1; in_valid = 1'b0; m_op = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in1 = 32'd0; in2 = 32'd0; op = 4'd0; funct3 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ov", {31'd0, out_valid}, 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        chk("rst.neg", {31'd0, negative}, 32'd0);
        chk("rst.ill", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst.rdy", {31'd0, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 23; i++)
            run_op(tbl[i].m, tbl[i].o, tbl[i].f, tbl[i].a, tbl[i].b,
                   tbl[i].exp, tbl[i].ill, tbl[i].lat, $sformatf("tbl%0d", i));

        // Back-to-back base ops, one result per cycle
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; m_op = tbl[i].m; op = tbl[i].o; funct3 = tbl[i].f;
            in1 = tbl[i].a; in2 = tbl[i].b;
            chk("b2b.rdy", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            chk("b2b.ov", {31'd0, out_valid}, 32'd1);
            chk("b2b.res", result, tbl[i].exp);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure after a mul completes
        out_ready = 1'b0;
        in_valid = 1'b1; m_op = 1'b1; funct3 = 3'd0; in1 = 32'd3; in2 = 32'd5;
        @(posedge clk); #1;
        chk("bp.busy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; m_op = 1'b0; op = 4'd0; in1 = 32'd1; in2 = 32'd1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp.lat", 32'(n), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold.res", result, 32'd15);
            chk("bp.hold.ov", {31'd0, out_valid}, 32'd1);
            chk("bp.hold.rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.rel.ov", {31'd0, out_valid}, 32'd0);
        chk("bp.rel.rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next.ov", {31'd0, out_valid}, 32'd1);
        chk("bp.next.res", result, 32'd2);
        @(posedge clk); #1;

        // Flush during iteration 10 of a div
        in_valid = 1'b1; m_op = 1'b1; funct3 = 3'd4; in1 = 32'd1000; in2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.ov", {31'd0, out_valid}, 32'd0);
        chk("flush.rdy", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush.never", 32'(seen), 32'd0);
        run_op(1'b0, 4'd0, 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 0, "flush.add");

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rm = ($urandom_range(0, 2) == 0);
            ro = 4'($urandom_range(0, 15));
            rf = 3'($urandom_range(0, 7));
            ra = rnd_operand();
            rb = rnd_operand();
            r  = model(rm, ro, rf, ra, rb);
            run_op(rm, ro, rf, ra, rb, r[31:0], r[32], model_lat(rm, rf, ra, rb),
                   $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a mul
        run_op(1'b0, 4'd0, 3'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 0, "pre_rst");
        in_valid = 1'b1; m_op = 1'b1; funct3 = 3'd0; in1 = 32'd7; in2 = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("mrst.ov", {31'd0, out_valid}, 32'd0);
        chk("mrst.res", result, 32'd0);
        chk("mrst.zero", {31'd0, zero}, 32'd1);
        chk("mrst.neg", {31'd0, negative}, 32'd0);
        chk("mrst.ill", {31'd0, illegal}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("mrst.rdy", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mrst.never", 32'(seen), 32'd0);
        run_op(1'b0, 4'b1111, 3'd0, 32'd1, 32'd2, 32'd0, 1'b1, 0, "ill15");

        // M op on the EN_M=0 instance is illegal; EN_M=1 instance computes it
        @(posedge clk); #1;
        in_valid = 1'b1; m_op = 1'b1; funct3 = 3'd0; in1 = 32'd3; in2 = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("nom.ov", {31'd0, out_valid0}, 32'd1);
        chk("nom.ill", {31'd0, illegal0}, 32'd1);
        chk("nom.res", result0, 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("m.lat", 32'(n), 32'd33);
        chk("m.res", result, 32'd15);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
